uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path (tx controller, data register, shift register) between NUM_REQ byte producers.
- Arbitrates round-robin and accepts one byte per grant on a valid/ready handshake.
- Sequences the tx controller through its load, byte-ready and transmit strobes, then waits for end-of-frame.
- Sits between the requesting blocks and the tx controller. A watchdog recovers if end-of-frame never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width.
- TIMEOUT, 2048, max cycles in WAIT_DONE before abort (must be >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- reqValid  input  NUM_REQ  per-requester byte-available flags.
- reqData  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- reqReady  output  NUM_REQ  one-hot accept; byte i transferred when reqValid[i] & reqReady[i].
- txDone  input  1  one-cycle end-of-frame pulse from the tx path (bit count reached max, stop bit sent).
- dataOut  output  DATA_WIDTH  held byte driven to the tx data register.
- loadDataReg  output  1  one-cycle strobe: data register loads dataOut.
- byteReady  output  1  one-cycle strobe to the tx controller: data register holds a valid byte.
- transmitByte  output  1  one-cycle strobe to the tx controller: start frame.
- busy  output  1  high in every state except IDLE.
- grantId  output  clog2(NUM_REQ)  index of the requester being served; valid while busy.
- errTimeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset:
  - All outputs 0. State IDLE. Held byte 0. Watchdog counter 0. lastGrant = NUM_REQ-1, so requester 0 has first priority.
  - rst mid-operation aborts immediately: byte dropped, no strobes in the following cycle.
- States (registered, one-hot): IDLE, LOAD, READY, START, WAIT_DONE.
- IDLE:
  - If any reqValid: select the first set bit searching from (lastGrant+1) mod NUM_REQ upward with wrap.
  - Drive reqReady[g]=1 combinationally in the same cycle. Capture reqData[g] into the held register. Set grantId=g and lastGrant=g. Next state LOAD.
  - Otherwise reqReady=0 and stay in IDLE.
- LOAD: loadDataReg=1 for one cycle, dataOut = held byte. Next state READY.
- READY: byteReady=1 for one cycle. Next state START.
- START: transmitByte=1 for one cycle. Clear watchdog. Next state WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - txDone=1 -> IDLE.
  - Else if watchdog == TIMEOUT-1 -> errTimeout=1 for one cycle, then IDLE.
  - txDone and timeout in the same cycle: txDone wins, no errTimeout.
- dataOut holds the captured byte from LOAD until the next capture; it does not change during WAIT_DONE.
- Strobes are registered, mutually exclusive and never asserted outside their state.
- reqReady is 0 in every state other than IDLE. At most one reqReady bit is set at any time.
- txDone outside WAIT_DONE is ignored.
- Requester timing:
  - A requester dropping reqValid before grant loses nothing.
  - After its byte is accepted, a requester holding reqValid is re-considered only after all other pending requesters rotate past it.
- Latency:
  - Accept at cycle T; loadDataReg at T+1; byteReady at T+2; transmitByte at T+3.
  - Earliest next accept is the cycle after txDone is seen.
- Single requester continuously valid: served back-to-back, with one IDLE cycle between frames.

Test Plan:
- Reset, then reqValid=4'b0001, reqData[0]=8'hA5:
  - reqReady=0001 at accept cycle T.
  - loadDataReg at T+1 with dataOut=A5, byteReady at T+2, transmitByte at T+3.
  - txDone at T+10 -> busy drops at T+11.
- All four requesters valid continuously, data 8'h10..8'h13: grant order 0,1,2,3,0; each dataOut matches its grantId; exactly one frame per txDone.
- lastGrant=1 with requesters 0 and 3 valid: grant goes to 3, then to 0.
- TIMEOUT=16, never assert txDone after START: errTimeout pulses exactly 16 cycles after START; return to IDLE; next request accepted normally.
- Assert rst for one cycle while in READY: next cycle all outputs 0 and state IDLE; requester 0 has priority again.
- txDone pulsed in IDLE and LOAD: no state change, no extra strobes; txDone in the same cycle as watchdog expiry -> errTimeout stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// Bundle between byte producers, the shared UART tx controller and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);

   logic [NUM_REQ-1:0]            reqValid;
   logic [NUM_REQ*DATA_WIDTH-1:0] reqData;
   logic [NUM_REQ-1:0]            reqReady;
   logic                          txDone;
   logic [DATA_WIDTH-1:0]         dataOut;
   logic                          loadDataReg;
   logic                          byteReady;
   logic                          transmitByte;
   logic                          busy;
   logic [$clog2(NUM_REQ)-1:0]    grantId;
   logic                          errTimeout;

   modport master (
      output reqValid, reqData, txDone,
      input  reqReady, dataOut, loadDataReg, byteReady, transmitByte,
             busy, grantId, errTimeout
   );

   modport slave (
      input  reqValid, reqData, txDone,
      output reqReady, dataOut, loadDataReg, byteReady, transmitByte,
             busy, grantId, errTimeout
   );

endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one UART tx path among NUM_REQ byte producers:
// accepts one byte per grant, sequences load/byte-ready/transmit, then waits for end-of-frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 2048
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int IW = GW + 1;
   localparam int WW = $clog2(TIMEOUT) + 1;

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      LOAD      = 5'b00010,
      READY     = 5'b00100,
      START     = 5'b01000,
      WAIT_DONE = 5'b10000
   } state_t;

   state_t                state;
   state_t                stateNext;
   logic [DATA_WIDTH-1:0] heldByte;
   logic [DATA_WIDTH-1:0] pickData;
   logic [GW-1:0]         lastGrant;
   logic [GW-1:0]         grantReg;
   logic [GW-1:0]         pick;
   logic [GW-1:0]         candIdx;
   logic [IW-1:0]         idx;
   logic                  anyValid;
   logic                  accept;
   logic                  wdExpired;
   logic [WW-1:0]         watchdog;

   // Walk from the farthest candidate (lastGrant itself) to the nearest (lastGrant+1);
   // the last hit wins, which yields the first valid requester after lastGrant.
   always_comb begin
      pick     = '0;
      anyValid = 1'b0;
      idx      = '0;
      candIdx  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = {1'b0, lastGrant} + IW'(i);
         if (idx >= IW'(NUM_REQ))
            idx = idx - IW'(NUM_REQ);
         candIdx = idx[GW-1:0];
         if (bus.reqValid[candIdx]) begin
            pick     = candIdx;
            anyValid = 1'b1;
         end
      end
   end

   always_comb begin
      pickData = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick == GW'(i))
            pickData = bus.reqData[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign accept    = (state == IDLE) && anyValid && !rst;
   assign wdExpired = (watchdog == WW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // txDone outranks a simultaneous watchdog expiry.
   always_comb begin
      stateNext      = state;
      bus.reqReady   = '0;
      bus.errTimeout = 1'b0;
      case (state)
         IDLE: begin
            if (anyValid) begin
               stateNext = LOAD;
               if (!rst)
                  bus.reqReady[pick] = 1'b1;
            end
         end
         LOAD:  stateNext = READY;
         READY: stateNext = START;
         START: stateNext = WAIT_DONE;
         WAIT_DONE: begin
            if (bus.txDone) begin
               stateNext = IDLE;
            end else if (wdExpired) begin
               stateNext      = IDLE;
               bus.errTimeout = !rst;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         heldByte  <= '0;
         grantReg  <= '0;
         lastGrant <= GW'(NUM_REQ - 1);
         watchdog  <= '0;
      end else begin
         if (accept) begin
            heldByte  <= pickData;
            grantReg  <= pick;
            lastGrant <= pick;
         end
         if (state == START)
            watchdog <= '0;
         else if (state == WAIT_DONE)
            watchdog <= watchdog + WW'(1);
      end
   end

   // Strobes decode straight from the one-hot state flops, so they are glitch-free.
   assign bus.dataOut      = heldByte;
   assign bus.loadDataReg  = (state == LOAD);
   assign bus.byteReady    = (state == READY);
   assign bus.transmitByte = (state == START);
   assign bus.busy         = (state != IDLE);
   assign bus.grantId      = grantReg;

   assert property (@(posedge clk) disable iff (rst) $onehot0(bus.reqReady));
   assert property (@(posedge clk) disable iff (rst)
      $onehot0({bus.loadDataReg, bus.byteReady, bus.transmitByte, bus.errTimeout}));
   assert property (@(posedge clk) disable iff (rst) $onehot(state));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a cycle-age based reference model.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int TIMEOUT    = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   loadCount = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always @(posedge clk) if (bus.loadDataReg) loadCount <= loadCount + 1;

   typedef struct {
      logic        r;
      logic        chk;
      logic [3:0]  v;
      logic [31:0] d;
      logic        done;
      logic [3:0]  eReady;
      logic [7:0]  eData;
      logic [3:0]  eStrb;   // {loadDataReg, byteReady, transmitByte, busy}
      logic [1:0]  eGid;
      logic        eErr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(input logic r, input logic c, input logic [3:0] v,
                                  input logic [31:0] d, input logic dn, input logic [3:0] rr,
                                  input logic [7:0] od, input logic [3:0] st,
                                  input logic [1:0] g, input logic e);
      vec_t x;
      x.r = r; x.chk = c; x.v = v; x.d = d; x.done = dn;
      x.eReady = rr; x.eData = od; x.eStrb = st; x.eGid = g; x.eErr = e;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] rr, input logic [7:0] od,
                           input logic [3:0] st, input logic [1:0] g, input logic e);
      check({tag, ".reqReady"},     32'(bus.reqReady),     32'(rr));
      check({tag, ".dataOut"},      32'(bus.dataOut),      32'(od));
      check({tag, ".loadDataReg"},  32'(bus.loadDataReg),  32'(st[3]));
      check({tag, ".byteReady"},    32'(bus.byteReady),    32'(st[2]));
      check({tag, ".transmitByte"}, 32'(bus.transmitByte), 32'(st[1]));
      check({tag, ".busy"},         32'(bus.busy),         32'(st[0]));
      check({tag, ".grantId"},      32'(bus.grantId),      32'(g));
      check({tag, ".errTimeout"},   32'(bus.errTimeout),   32'(e));
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1; bus.reqValid = '0; bus.reqData = '0; bus.txDone = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model: tracks only how many cycles have passed since the accept.
   int         mAge;
   int         mLast;
   int         mGrant;
   logic [7:0] mHeld;

   task automatic modelReset();
      mAge = -1; mLast = NUM_REQ - 1; mGrant = 0; mHeld = 8'h00;
   endtask

   task automatic modelCycle(input logic r, input logic [3:0] v, input logic [31:0] d,
                             input logic dn);
      logic [3:0] eReady;
      logic [3:0] st;
      logic [1:0] ix;
      int         pick;
      logic       eErr;
      logic       fin;
      eReady = '0; pick = -1; eErr = 1'b0; fin = 1'b0; st = '0;
      if (mAge < 0) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            ix = 2'((mLast + k) % NUM_REQ);
            if (pick < 0 && v[ix]) begin
               pick = (mLast + k) % NUM_REQ;
               eReady[ix] = 1'b1;
            end
         end
      end else begin
         st = {mAge == 1, mAge == 2, mAge == 3, 1'b1};
         if (mAge >= 4) begin
            fin  = dn || (mAge == 3 + TIMEOUT);
            eErr = !dn && (mAge == 3 + TIMEOUT);
         end
      end
      if (!r)
         checkAll("rand", eReady, mHeld, st, 2'(mGrant), eErr);
      if (r) begin
         modelReset();
      end else if (mAge < 0) begin
         if (pick >= 0) begin
            mAge = 1; mGrant = pick; mLast = pick; mHeld = 8'(d >> (8 * pick));
         end
      end else if (fin) begin
         mAge = -1;
      end else begin
         mAge++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL globalTimeout: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int g;
      int waitC;
      int k;
      int l0;
      logic seen;

      bus.reqValid = '0; bus.reqData = '0; bus.txDone = 1'b0;

      // r, chk, v, d, done, reqReady, dataOut, {load,byteReady,transmit,busy}, grantId, err
      vecs.push_back(mkVec(1, 0, 4'h0, 32'h0,        0, 4'h0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(1, 0, 4'h0, 32'h0,        0, 4'h0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h1, 32'h000000A5, 0, 4'h1, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'hA5, 4'b1001, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'hA5, 4'b0101, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'hA5, 4'b0011, 0, 0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,     0, 4'h0, 8'hA5, 4'b0001, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        1, 4'h0, 8'hA5, 4'b0001, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'hA5, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        1, 4'h0, 8'hA5, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h4, 32'h003C0000, 0, 4'h4, 8'hA5, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        1, 4'h0, 8'h3C, 4'b1001, 2, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'h3C, 4'b0101, 2, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'h3C, 4'b0011, 2, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        1, 4'h0, 8'h3C, 4'b0001, 2, 0));
      vecs.push_back(mkVec(0, 1, 4'h8, 32'h77000000, 0, 4'h8, 8'h3C, 4'b0000, 2, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'h77, 4'b1001, 3, 0));
      vecs.push_back(mkVec(1, 1, 4'h9, 32'h77000011, 0, 4'h0, 8'h77, 4'b0101, 3, 0));
      vecs.push_back(mkVec(0, 1, 4'h0, 32'h0,        0, 4'h0, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h1, 8'h00, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h0, 8'h11, 4'b1001, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h0, 8'h11, 4'b0101, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h0, 8'h11, 4'b0011, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 1, 4'h0, 8'h11, 4'b0001, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h8, 8'h11, 4'b0000, 0, 0));
      vecs.push_back(mkVec(0, 1, 4'h9, 32'h77000011, 0, 4'h0, 8'h77, 4'b1001, 3, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].r; bus.reqValid = vecs[i].v; bus.reqData = vecs[i].d;
         bus.txDone = vecs[i].done;
         #1;
         if (vecs[i].chk)
            checkAll($sformatf("vec%0d", i), vecs[i].eReady, vecs[i].eData, vecs[i].eStrb,
                     vecs[i].eGid, vecs[i].eErr);
      end

      // All four requesters continuously valid: grants rotate 0,1,2,3,0.
      applyReset();
      l0 = loadCount;
      bus.reqValid = 4'hF; bus.reqData = 32'h13121110;
      for (int f = 0; f < 5; f++) begin
         waitC = 0;
         #1;
         while (bus.reqReady == 4'h0 && waitC < 20) begin
            @(negedge clk); #1; waitC++;
         end
         g = -1;
         for (int i = 0; i < NUM_REQ; i++) if (bus.reqReady[i]) g = i;
         check("rrOrder", 32'(g), 32'(f % 4));
         @(negedge clk); #1;
         check("rrLoad", 32'(bus.loadDataReg), 32'd1);
         check("rrData", 32'(bus.dataOut), 32'(8'h10 + 8'(f % 4)));
         check("rrGrantId", 32'(bus.grantId), 32'(f % 4));
         @(negedge clk); @(negedge clk); #1;
         check("rrTransmit", 32'(bus.transmitByte), 32'd1);
         @(negedge clk);
         bus.txDone = 1'b1;
         if (f == 4) bus.reqValid = 4'h0;
         @(negedge clk);
         bus.txDone = 1'b0;
      end
      #1;
      check("rrIdleAfter", 32'(bus.busy), 32'd0);
      check("rrFrameCount", 32'(loadCount - l0), 32'd5);

      // Watchdog expiry with no txDone, then a normal accept.
      applyReset();
      bus.reqValid = 4'h1; bus.reqData = 32'h000000C3;
      #1;
      check("toAccept", 32'(bus.reqReady), 32'h1);
      @(negedge clk); bus.reqValid = 4'h0;
      @(negedge clk);
      @(negedge clk); #1;
      check("toTransmit", 32'(bus.transmitByte), 32'd1);
      k = 0; seen = 1'b0;
      while (!seen && k < 40) begin
         @(negedge clk); #1; k++;
         if (bus.errTimeout) seen = 1'b1;
      end
      check("toDelay", 32'(k), 32'(TIMEOUT));
      check("toBusyAtErr", 32'(bus.busy), 32'd1);
      @(negedge clk); #1;
      check("toErrOneCycle", 32'(bus.errTimeout), 32'd0);
      check("toIdle", 32'(bus.busy), 32'd0);
      bus.reqValid = 4'h2; bus.reqData = 32'h00005A00;
      #1;
      check("toNextAccept", 32'(bus.reqReady), 32'h2);
      @(negedge clk); bus.reqValid = 4'h0; #1;
      check("toNextLoad", 32'(bus.loadDataReg), 32'd1);
      check("toNextData", 32'(bus.dataOut), 32'h5A);
      check("toNextGrant", 32'(bus.grantId), 32'd1);

      // txDone arriving on the expiry cycle suppresses errTimeout.
      @(negedge clk);
      @(negedge clk); #1;
      check("coTransmit", 32'(bus.transmitByte), 32'd1);
      for (int j = 1; j <= TIMEOUT; j++) begin
         @(negedge clk);
         bus.txDone = (j == TIMEOUT);
         #1;
         check($sformatf("coNoErr%0d", j), 32'(bus.errTimeout), 32'd0);
         if (j == TIMEOUT) check("coBusy", 32'(bus.busy), 32'd1);
      end
      @(negedge clk); bus.txDone = 1'b0; #1;
      check("coIdle", 32'(bus.busy), 32'd0);
      check("coErrAfter", 32'(bus.errTimeout), 32'd0);

      // Randomized traffic against the reference model.
      applyReset();
      modelReset();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         bus.reqValid = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         bus.reqData  = $urandom;
         bus.txDone   = ($urandom_range(0, 11) == 0);
         #1;
         modelCycle(rst, bus.reqValid, bus.reqData, bus.txDone);
         @(negedge clk);
      end
      rst = 1'b0; bus.reqValid = '0; bus.txDone = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
